// File: rtl/md_unit_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO and models fixed-latency busy.
// Optional macro MD_ABORT_EN: a flush during RUN aborts the in-flight operation.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic        md_flush,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_rd_sel,
  output logic        md_busy,
  output logic [31:0] md_rd,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q, p_hi_q, p_lo_q;
  logic        p_wr_q;

  logic        accept, is_mul, is_div, abort;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  assign accept = md_start && !md_flush && (state_q == S_IDLE);
  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);

`ifdef MD_ABORT_EN
  assign abort = md_flush;
`else
  assign abort = 1'b0;
`endif

  // Sign-extending to 64 bits makes a plain 64-bit multiply produce the signed product.
  always_comb begin
    if (md_op == OP_MULT)
      prod = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
    else
      prod = {32'd0, md_a} * {32'd0, md_b};
  end

  logic        sgn, neg_a, neg_b;
  logic [31:0] abs_a, abs_b, dvsr, uq, ur, quo, rem;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  always_comb begin
    sgn   = (md_op == OP_DIV);
    neg_a = sgn && md_a[31];
    neg_b = sgn && md_b[31];
    abs_a = neg_a ? (~md_a + 32'd1) : md_a;
    abs_b = neg_b ? (~md_b + 32'd1) : md_b;
    dvsr  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq    = abs_a / dvsr;
    ur    = abs_a % dvsr;
    quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem   = neg_a ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (is_mul || is_div)) state_d = S_RUN;
      S_RUN:  if (abort || (cnt_q <= 4'd1))     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state_q == S_RUN);
    md_hi   = hi_q;
    md_lo   = lo_q;
    md_rd   = md_rd_sel ? hi_q : lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      p_wr_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (accept && (is_mul || is_div)) begin
        p_hi_q <= res_hi;
        p_lo_q <= res_lo;
        p_wr_q <= !(is_div && (md_b == 32'd0));
        cnt_q  <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (accept && (md_op == OP_MTHI)) begin
        hi_q <= md_a;
      end else if (accept && (md_op == OP_MTLO)) begin
        lo_q <= md_a;
      end
    end else begin
      cnt_q <= cnt_q - 4'd1;
      if (abort) begin
        cnt_q  <= 4'd0;
        p_wr_q <= 1'b0;
      end else if (cnt_q <= 4'd1) begin
        if (p_wr_q) begin
          hi_q <= p_hi_q;
          lo_q <= p_lo_q;
        end
        p_wr_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Sequencing controller for the EX-stage multiply/divide resource. Accepts mult/multu/div/divu/mthi/mtlo operations from EX, holds the HI/LO architectural registers, and models fixed multi-cycle latency with a registered busy flag. The pipeline hazard controller consumes `md_busy` together with `md_start` to stall md-class instructions in ID. It also honours the exception/interrupt flush so that a squashed instruction never modifies HI/LO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `md_start`  in  1  valid md-class op in EX this cycle.
- `md_op`  in  3  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `md_flush`  in  1  EX instruction squashed by exception or interrupt this cycle.
- `md_a`  in  32  rs operand, already forwarded.
- `md_b`  in  32  rt operand, already forwarded.
- `md_rd_sel`  in  1  mfhi/mflo select: 0 = LO, 1 = HI.
- `md_busy`  out  1  registered; operation in flight.
- `md_rd`  out  32  combinational read of HI or LO, selected by `md_rd_sel`.
- `md_hi`  out  32  current HI register.
- `md_lo`  out  32  current LO register.

## Operation
- States:
  - IDLE: `md_busy` = 0.
  - RUN: `md_busy` = 1, with 4-bit down-counter `cnt`.
- Accept condition: `md_start && !md_flush && !md_busy`. Otherwise the op is ignored and no state changes.
- IDLE with an accepted mult, multu, div or divu:
  - capture the result into pending registers `p_hi`/`p_lo`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE with an accepted mthi/mtlo: write `md_a` into HI/LO at that edge. Stay IDLE.
- RUN:
  - `cnt` decrements each edge;
  - at the edge where `cnt` == 1, commit `p_hi`/`p_lo` to HI/LO and return to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product. HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: signed. LO = quotient, truncated toward zero. HI = remainder, sign follows the dividend.
  - divu: unsigned.
- Divide by zero: still occupies RUN for DIV_CYCLES. The commit is suppressed, so HI/LO are unchanged.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- `md_start` while busy: ignored. The hazard controller must prevent this; the bench checks that HI/LO are untouched.
- `md_rd`, `md_hi` and `md_lo` reflect HI/LO as of the last edge. A commit or mthi/mtlo write is visible in the cycle after the edge.

## Timing
- Reset (`rst_n` = 0 at an edge): HI = 0, LO = 0, `md_busy` = 0, `cnt` = 0, pending registers = 0, state IDLE.
- Reset mid-operation: the in-flight result is discarded and HI/LO are cleared.
- Accepted multi-cycle op at edge E0:
  - `md_busy` is high from E0 through E_N, exactly N cycles;
  - HI/LO take the new value at edge E_N;
  - a new start is accepted at edge E_N+1 at the earliest.
- mthi/mtlo: zero busy cycles. The value is visible the cycle after the accepting edge.
- `md_flush` together with `md_start` in the same cycle: the op is dropped, including mthi/mtlo.
- `md_flush` while in RUN: behaviour depends on the configuration below.

## Configuration
- `MD_ABORT_EN`:
  - Defined: `md_flush` asserted while in RUN aborts the operation. Next edge: state IDLE, `md_busy` = 0, HI/LO unchanged, pending result discarded. A flush on the commit edge (`cnt` == 1) also suppresses the commit.
  - Undefined: `md_flush` has no effect on an in-flight operation. It always runs to completion and commits.

## Test plan
- Signed mult: mult -3 × 5 → `md_busy` high exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Before commit, HI/LO still hold their old values.
- Unsigned mult: multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- Division cases:
  - div -7 / 2 → 10 busy cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu 7 / 0 → 10 busy cycles; HI/LO unchanged.
  - div 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- Direct writes and ignored ops:
  - mthi 0x12345678 → HI updated next cycle, `md_busy` stays 0;
  - mult started while busy → ignored, final result equals the first op only;
  - `md_rd_sel` toggle returns HI/LO correctly.
- Flush behaviour:
  - start mult with `md_flush` = 1 → no busy, HI/LO unchanged;
  - flush on busy cycle 3 of a mult with `MD_ABORT_EN` → busy drops next cycle, HI/LO unchanged;
  - same stimulus without the macro → commit happens on cycle 5.
- Reset: `rst_n` low on busy cycle 2 of a div → next cycle `md_busy` = 0, HI = LO = 0; no late commit occurs.
